// File: rtl/encoder_poll_sched.sv
// Round-robin SPI poll scheduler for N_CH absolute encoders sharing one MISO line.
// Periodic ticks and on-demand requests feed a pending vector; one frame is read at a time.
module encoder_poll_sched #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic            sck,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N_CH-1:0] ch_en,
  input  logic [15:0]     period,
  input  logic [N_CH-1:0] req,
  input  logic            miso,
  output logic [N_CH-1:0] cs_n,
  output logic            busy,
  output logic            data_valid,
  output logic [1:0]      data_ch,
  output logic [23:0]     encoder_val_full,
  output logic [18:0]     encoder_val
);

  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_MAX = (FRAME_BITS > GAP_CYCLES) ? FRAME_BITS : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned VAL_W   = 24;

  typedef enum logic [1:0] {IDLE, SELECT, SHIFT, GAP} state_t;

  state_t            state, state_nxt;
  logic [15:0]       timer, timer_nxt;
  logic              tick;
  logic [N_CH-1:0]   pend, pend_nxt, pend_set, grant_oh;
  logic [CH_W-1:0]   sel, sel_nxt, last_ch, last_ch_nxt, rr_idx;
  logic              rr_found;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [VAL_W-2:0]  shreg, shreg_nxt;
  logic [VAL_W-1:0]  val_nxt;
  logic [N_CH-1:0]   cs_n_nxt;
  logic              busy_nxt, dv_nxt;
  logic [1:0]        data_ch_nxt;

  assign encoder_val = encoder_val_full[21:3];

  // Free-running poll timer; held at zero when periodic polling is off
  always_comb begin
    tick      = 1'b0;
    timer_nxt = '0;
    if (enable && period != 16'd0) begin
      tick      = (timer == period - 16'd1);
      timer_nxt = (timer >= period - 16'd1) ? 16'd0 : timer + 16'd1;
    end
  end

  // First pending channel after the last one served
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_ch;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      if (!rr_found && pend[CH_W'((32'(last_ch) + i) % N_CH)]) begin
        rr_found = 1'b1;
        rr_idx   = CH_W'((32'(last_ch) + i) % N_CH);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    last_ch_nxt = last_ch;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    val_nxt     = encoder_val_full;
    cs_n_nxt    = cs_n;
    dv_nxt      = 1'b0;
    data_ch_nxt = data_ch;
    grant_oh    = '0;

    case (state)
      IDLE: begin
        if (enable && rr_found) begin
          sel_nxt     = rr_idx;
          last_ch_nxt = rr_idx;
          grant_oh    = N_CH'(1) << rr_idx;
          cs_n_nxt    = ~(N_CH'(1) << rr_idx);
          cnt_nxt     = '0;
          state_nxt   = SELECT;
        end
      end
      SELECT: begin
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shreg_nxt = {shreg[VAL_W-3:0], miso};
        if (cnt == CNT_W'(FRAME_BITS - 1)) begin
          val_nxt     = {shreg, miso};
          data_ch_nxt = 2'(sel);
          cs_n_nxt    = '1;
          dv_nxt      = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
    // A new request in the grant cycle keeps the channel pending
    pend_set = (req | {N_CH{tick}}) & ch_en;
    pend_nxt = enable ? ((pend & ~grant_oh) | pend_set) : '0;
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      timer            <= '0;
      pend             <= '0;
      sel              <= '0;
      last_ch          <= CH_W'(N_CH - 1);
      cnt              <= '0;
      shreg            <= '0;
      encoder_val_full <= '0;
      cs_n             <= '1;
      busy             <= 1'b0;
      data_valid       <= 1'b0;
      data_ch          <= '0;
    end else begin
      state            <= state_nxt;
      timer            <= timer_nxt;
      pend             <= pend_nxt;
      sel              <= sel_nxt;
      last_ch          <= last_ch_nxt;
      cnt              <= cnt_nxt;
      shreg            <= shreg_nxt;
      encoder_val_full <= val_nxt;
      cs_n             <= cs_n_nxt;
      busy             <= busy_nxt;
      data_valid       <= dv_nxt;
      data_ch          <= data_ch_nxt;
    end
  end

endmodule

// File: tb/tb_encoder_poll_sched.sv
// Bench for encoder_poll_sched: scenario table, corner-case sequences and random traffic,
// all checked cycle by cycle against a timestamp-based model of the poll schedule.
module tb_encoder_poll_sched;

  localparam int N    = 4;
  localparam int FB   = 24;
  localparam int GAPC = 4;
  localparam int LAST = FB + GAPC;

  logic        sck = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        miso = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [3:0]  req = '0;
  logic [15:0] period = '0;
  logic [3:0]  cs_n;
  logic        busy, data_valid;
  logic [1:0]  data_ch;
  logic [23:0] encoder_val_full;
  logic [18:0] encoder_val;

  encoder_poll_sched #(.N_CH(N), .FRAME_BITS(FB), .GAP_CYCLES(GAPC)) dut (
    .sck(sck), .rst_n(rst_n), .enable(enable), .ch_en(ch_en), .period(period),
    .req(req), .miso(miso), .cs_n(cs_n), .busy(busy), .data_valid(data_valid),
    .data_ch(data_ch), .encoder_val_full(encoder_val_full), .encoder_val(encoder_val)
  );

  always #5 sck = ~sck;

  int checks = 0;
  int errors = 0;

  // Model: a frame is a timestamp; everything else follows from the offset into it
  int          cyc;
  int          m_start;
  int          m_cur;
  int          m_last;
  logic [3:0]  m_pend;
  int          m_run;
  logic [23:0] m_frame, m_full;
  logic [1:0]  m_ch;
  int          obs_ch[$];
  bit          use_pat;
  logic [23:0] pat;

  typedef struct {
    logic        en;
    logic [3:0]  ce;
    logic [15:0] per;
    logic [3:0]  rq;
    int          ncyc;
    bit          use_pat;
    logic [23:0] pat;
    int          nfr;
    logic [7:0]  seq;
    logic        busy_end;
    logic [18:0] val;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    cyc = 0; m_start = -1000; m_cur = 0; m_last = N - 1; m_pend = '0; m_run = 0;
    m_frame = '0; m_full = '0; m_ch = '0;
    obs_ch.delete();
  endfunction

  task automatic do_reset();
    enable = 1'b0; ch_en = '0; period = '0; req = '0; miso = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge sck); @(posedge sck); #1;
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_data_ch", 32'(data_ch), 32'h0);
    chk("rst_val_full", 32'(encoder_val_full), 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_cycle();
    int off;
    bit act;
    logic [3:0] exp_cs;
    off = cyc - m_start;
    act = (off >= 0) && (off <= LAST);
    exp_cs = (act && off <= FB) ? ~(4'b0001 << m_cur) : 4'hF;
    chk("cs_n", 32'(cs_n), 32'(exp_cs));
    chk("busy", 32'(busy), 32'(act));
    chk("data_valid", 32'(data_valid), 32'(act && off == FB + 1));
    chk("val_full", 32'(encoder_val_full), 32'(m_full));
    chk("val", 32'(encoder_val), 32'(m_full[21:3]));
    chk("data_ch", 32'(data_ch), 32'(m_ch));
    if (data_valid === 1'b1) obs_ch.push_back(int'(data_ch));
  endtask

  task automatic run_cycle(input logic en, input logic [3:0] ce, input logic [15:0] per,
                           input logic [3:0] rq);
    int off;
    bit act, tick;
    int ch;
    check_cycle();
    off = cyc - m_start;
    act = (off >= 0) && (off <= LAST);
    enable = en; ch_en = ce; period = per; req = rq;
    if (use_pat) miso = (act && off >= 1 && off <= FB) ? pat[FB - off] : 1'b0;
    else         miso = 1'($urandom);
    tick = 1'b0;
    if (en && per != 16'd0) tick = (m_run % int'(per)) == (int'(per) - 1);
    if (act && off >= 1 && off <= FB) m_frame = {m_frame[22:0], miso};
    if (act && off == FB) begin
      m_full = m_frame;
      m_ch   = 2'(m_cur);
    end
    if (!act && en && m_pend != 4'h0) begin
      ch = 0;
      for (int i = 1; i <= N; i++) begin
        ch = (m_last + i) % N;
        if (m_pend[ch]) break;
      end
      m_cur = ch; m_last = ch; m_start = cyc + 1; m_pend[ch] = 1'b0; m_frame = '0;
    end
    if (en) m_pend = m_pend | ((rq | {4{tick}}) & ce);
    else    m_pend = '0;
    m_run = (en && per != 16'd0) ? m_run + 1 : 0;
    cyc++;
    @(posedge sck); #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'hF, 16'd0,   4'b1010, 80,  1'b0, 24'h0,      2, 8'h0D, 1'b0, 19'h0};
    vecs[1] = '{1'b1, 4'hF, 16'd20,  4'b0000, 160, 1'b0, 24'h0,      4, 8'hE4, 1'b1, 19'h0};
    vecs[2] = '{1'b1, 4'h1, 16'd100, 4'b0000, 250, 1'b1, 24'hA5C3F0, 2, 8'h00, 1'b0, 19'h4B87E};
    vecs[3] = '{1'b0, 4'hF, 16'd10,  4'b1111, 40,  1'b0, 24'h0,      0, 8'h00, 1'b0, 19'h0};
    vecs[4] = '{1'b1, 4'h0, 16'd5,   4'b1111, 40,  1'b0, 24'h0,      0, 8'h00, 1'b0, 19'h0};
    vecs[5] = '{1'b1, 4'h4, 16'd1,   4'b0000, 100, 1'b0, 24'h0,      3, 8'h2A, 1'b1, 19'h0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      use_pat = vecs[v].use_pat;
      pat     = vecs[v].pat;
      for (int c = 0; c < vecs[v].ncyc; c++)
        run_cycle(vecs[v].en, vecs[v].ce, vecs[v].per, (c == 0) ? vecs[v].rq : 4'h0);
      chk($sformatf("vec%0d_frames", v), 32'(obs_ch.size()), 32'(vecs[v].nfr));
      for (int k = 0; k < vecs[v].nfr && k < obs_ch.size(); k++)
        chk($sformatf("vec%0d_ch%0d", v, k), 32'(obs_ch[k]), 32'(vecs[v].seq[2*k +: 2]));
      chk($sformatf("vec%0d_busy_end", v), 32'(busy), 32'(vecs[v].busy_end));
      if (vecs[v].use_pat) begin
        chk($sformatf("vec%0d_full", v), 32'(encoder_val_full), 32'(vecs[v].pat));
        chk($sformatf("vec%0d_val", v), 32'(encoder_val), 32'(vecs[v].val));
      end
    end

    // Enable dropped mid-frame: frame still completes, nothing left pending
    do_reset();
    use_pat = 1'b0;
    for (int c = 0; c < 100; c++)
      run_cycle((c < 13 || c >= 60), 4'h1, 16'd0,
                (c == 0) ? 4'h1 : ((c == 20) ? 4'hF : 4'h0));
    chk("endrop_frames", 32'(obs_ch.size()), 32'd1);
    chk("endrop_ch", 32'((obs_ch.size() > 0) ? obs_ch[0] : -1), 32'd0);
    chk("endrop_busy", 32'(busy), 32'd0);

    // Reset during SHIFT bit 12 of a ch1 frame
    do_reset();
    for (int c = 0; c < 15; c++)
      run_cycle(1'b1, 4'hF, 16'd0, (c == 0) ? 4'b0010 : 4'h0);
    chk("midrst_pre_cs", 32'(cs_n), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(cs_n), 32'hF);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_dv", 32'(data_valid), 32'h0);
    chk("midrst_frames", 32'(obs_ch.size()), 32'd0);
    @(posedge sck); #1;
    chk("midrst_full", 32'(encoder_val_full), 32'h0);
    chk("midrst_dv_hold", 32'(data_valid), 32'h0);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 40; c++)
      run_cycle(1'b1, 4'hF, 16'd0, (c == 0) ? 4'hF : 4'h0);
    chk("midrst_first_ch", 32'((obs_ch.size() > 0) ? obs_ch[0] : -1), 32'd0);

    // req[2] coincident with tick and again in the grant cycle: exactly two frames
    do_reset();
    for (int c = 0; c < 110; c++)
      run_cycle(1'b1, 4'h4, (c <= 20) ? 16'd20 : 16'd0,
                (c == 19 || c == 20) ? 4'b0100 : 4'h0);
    chk("dup_frames", 32'(obs_ch.size()), 32'd2);
    for (int k = 0; k < obs_ch.size(); k++)
      chk($sformatf("dup_ch%0d", k), 32'(obs_ch[k]), 32'd2);

    // Random traffic against the model
    do_reset();
    for (int b = 0; b < 10; b++) begin
      logic [3:0]  ce;
      logic [15:0] per;
      ce  = 4'($urandom_range(0, 15));
      per = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
      for (int c = 0; c < 300; c++)
        run_cycle((c != 0) && ($urandom_range(0, 49) != 0), ce, per,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_poll_sched.md
ENCODER_POLL_SCHED -- requirements
Module: encoder_poll_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of encoders sharing one SPI bus (each with its own chip select).
REQ-002 SHALL have parameter FRAME_BITS, default 24, bits per encoder frame.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, minimum cs_n-high cycles between frames.
REQ-004 SHALL have port sck  input  1  the only clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  scheduler run enable.
REQ-007 SHALL have port ch_en  input  N_CH  per-channel poll enable.
REQ-008 SHALL have port period  input  16  periodic poll interval in sck cycles; 0 disables periodic polling.
REQ-009 SHALL have port req  input  N_CH  one-cycle on-demand read requests.
REQ-010 SHALL have port miso  input  1  shared encoder serial data, MSB first.
REQ-011 SHALL have port cs_n  output  N_CH  per-channel chip selects, active low.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port data_valid  output  1  one-cycle frame-complete pulse.
REQ-014 SHALL have port data_ch  output  2  channel index of the frame.
REQ-015 SHALL have port encoder_val_full  output  24  raw captured frame.
REQ-016 SHALL have port encoder_val  output  19  position field, encoder_val_full[21:3], combinational.

Function
REQ-017 SHALL implement states IDLE, SELECT, SHIFT and GAP.
REQ-018 Period timer SHALL count 0..period-1 while enable=1 and period!=0, pulse tick on the cycle it holds period-1, then wrap to 0; otherwise it SHALL hold 0.
REQ-019 Pending vector pend SHALL be updated as pend |= (req | {N_CH{tick}}) & ch_en while enable=1, and SHALL clear to 0 while enable=0.
REQ-020 IDLE: if enable=1 and pend!=0, SHALL grant the first set pend bit searching round-robin from last_ch+1 (modulo N_CH), record sel and last_ch, clear pend[sel] in the same cycle, and go to SELECT.
REQ-021 A req or tick on a channel in the same cycle as its grant SHALL leave pend for that channel set (set wins over clear).
REQ-022 SELECT SHALL last 1 cycle with cs_n[sel]=0, bit counter cleared, then go to SHIFT.
REQ-023 SHIFT SHALL last exactly FRAME_BITS cycles with cs_n[sel]=0, shifting miso into the LSB of a 24-bit shift register each cycle.
REQ-024 On the final SHIFT cycle, encoder_val_full SHALL load the complete frame including the last bit, data_ch SHALL load sel, and the block SHALL enter GAP.
REQ-025 data_valid SHALL be high exactly on the first GAP cycle.
REQ-026 GAP SHALL hold all cs_n high for GAP_CYCLES cycles, then go to IDLE.
REQ-027 Timing: SELECT at cycle T gives bits sampled T+1..T+24, data_valid at T+25, IDLE at T+29, earliest next SELECT at T+30.
REQ-028 Deasserting enable or the in-flight ch_en bit during SELECT, SHIFT or GAP SHALL NOT abort the frame.
REQ-029 Outside SELECT and SHIFT, all cs_n SHALL be high; at most one cs_n bit SHALL be low at any time.
REQ-030 encoder_val_full and data_ch SHALL hold their values until the next frame completes.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=IDLE, cs_n=all ones, busy=0, data_valid=0, data_ch=0, encoder_val_full=0, pend=0, timer=0 and last_ch=N_CH-1, so that ch0 is granted first.
REQ-032 Reset asserted mid-frame SHALL raise cs_n immediately, emit no data_valid, and discard the partial frame.

Verification
REQ-033 ch_en=0001, period=100, miso driving 24'hA5C3F0 MSB first -> cs_n[0] low 25 cycles every 100 cycles; data_valid with encoder_val_full=24'hA5C3F0, encoder_val=19'h4B87E, data_ch=0.
REQ-034 period=0, ch_en=1111, single req=1010 pulse -> frames ch1 then ch3, SELECTs 30 cycles apart, then idle with busy=0.
REQ-035 ch_en=1111, period=20 -> grant order 0,1,2,3,0,...; no channel skipped; no duplicate frame from repeated ticks on an already-pending channel.
REQ-036 enable dropped at SHIFT bit 10 -> frame completes with data_valid, no further SELECT, pend=0.
REQ-037 rst_n pulsed low at SHIFT bit 12 -> cs_n=1111 within the same cycle, no data_valid, encoder_val_full=0; after release, ch0 is the first grant.
REQ-038 req[2] coinciding with tick, and req[2] again in ch2's grant cycle -> two ch2 frames total, no more.
